// File: rtl/evm_ballot_controller_pkg.sv
// evm_pkg: shared types and constants for the ballot controller slice.
// Holds the controller state encoding, the default candidate count, the
// width of the accepted-vote counter and a saturating increment helper.
package evm_pkg;

  // Default number of candidate buttons / vote strobes
  localparam int NUM_CAND_DEFAULT = 6;

  // Width of the accepted-vote counter presented to the counter block
  localparam int VOTE_CNT_W = 16;

  // Controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACK    = 2'd2,
    RESULT = 2'd3
  } state_t;

  // Increment that sticks at all-ones instead of wrapping back to zero
  function automatic logic [VOTE_CNT_W-1:0] sat_inc(input logic [VOTE_CNT_W-1:0] value);
    logic [VOTE_CNT_W-1:0] next_value;
    next_value = value;
    if (value != {VOTE_CNT_W{1'b1}}) begin
      next_value = value + VOTE_CNT_W'(1);
    end
    return next_value;
  endfunction

endpackage

// File: rtl/evm_ballot_controller_if.sv
// evm_ballot_controller_if: bundles the officer controls, candidate buttons
// and everything the controller drives toward the counter block and lamps.
// The master side (panel / testbench) drives mode, ballot_issue and button;
// the slave side (the controller) drives the remaining signals.
interface evm_ballot_controller_if
  import evm_pkg::*;
#(
  parameter int NUM_CAND = NUM_CAND_DEFAULT
);

  logic                  mode;
  logic                  ballot_issue;
  logic [NUM_CAND-1:0]   button;
  logic [NUM_CAND-1:0]   vote_pulse;
  logic                  count_mode;
  logic                  ballot_ready;
  logic                  vote_ack;
  logic                  multi_press_err;
  logic                  timeout_err;
  logic [VOTE_CNT_W-1:0] total_votes;

  modport master (
    output mode,
    output ballot_issue,
    output button,
    input  vote_pulse,
    input  count_mode,
    input  ballot_ready,
    input  vote_ack,
    input  multi_press_err,
    input  timeout_err,
    input  total_votes
  );

  modport slave (
    input  mode,
    input  ballot_issue,
    input  button,
    output vote_pulse,
    output count_mode,
    output ballot_ready,
    output vote_ack,
    output multi_press_err,
    output timeout_err,
    output total_votes
  );

endinterface

// File: rtl/evm_ballot_controller_button_debounce.sv
// button_debounce: one candidate button. The raw asynchronous input is
// passed through a two-flop synchroniser, then a run-length counter only
// lets the debounced level change once DEBOUNCE_CYC consecutive
// synchronised samples disagree with it. o_press is a one-cycle strobe
// that rises together with the debounced level on a 0->1 change.
module button_debounce
  import evm_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic i_button,
  output logic o_level,
  output logic o_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  logic             w_differs;
  logic             w_run_done;

  assign w_differs  = (r_sync2 != r_level);
  assign w_run_done = w_differs && (r_cnt == CNT_W'(DEBOUNCE_CYC - 1));

  // Two-flop synchroniser bringing the raw button into the clock domain
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_button;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive samples that disagree with the level; flip on a full run
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (!w_differs) begin
        r_cnt <= '0;
      end else if (w_run_done) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_press <= r_sync2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/evm_ballot_controller.sv
// evm_ballot_controller: front-end sequencer between the candidate buttons
// and the per-candidate vote counters. Debounces every button, opens a
// ballot when the officer issues one, turns exactly one press per ballot
// into a one-hot single-cycle vote strobe, and blocks all voting while the
// result display is selected. All outputs come straight from registers.
module evm_ballot_controller
  import evm_pkg::*;
#(
  parameter int NUM_CAND     = NUM_CAND_DEFAULT,
  parameter int DEBOUNCE_CYC = 4,
  parameter int ACK_CYC      = 8,
  parameter int TIMEOUT_CYC  = 1000
) (
  input  logic                     clock,
  input  logic                     reset,
  evm_ballot_controller_if.slave   bus
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYC + 1);
  localparam int ACKC_W  = $clog2(ACK_CYC + 1);

  state_t                r_state;
  logic                  r_mode;
  logic [NUM_CAND-1:0]   r_vote_pulse;
  logic                  r_ballot_ready;
  logic                  r_vote_ack;
  logic                  r_multi_err;
  logic                  r_timeout_err;
  logic [VOTE_CNT_W-1:0] r_total_votes;
  logic [TIMER_W-1:0]    r_timer;
  logic [ACKC_W-1:0]     r_ack_cnt;

  logic [NUM_CAND-1:0]   w_level;
  logic [NUM_CAND-1:0]   w_press;
  logic [NUM_CAND-1:0]   w_press_evt;
  logic                  w_single;
  logic                  w_multi;
  logic                  w_timer_done;
  logic                  w_ack_done;

  // One debouncer per candidate button
  for (genvar g = 0; g < NUM_CAND; g++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
      .clock    (clock),
      .reset    (reset),
      .i_button (bus.button[g]),
      .o_level  (w_level[g]),
      .o_press  (w_press[g])
    );
  end

  // A press strobe and its debounced level rise together, so qualifying the
  // strobe by the level never drops a real press event
  assign w_press_evt  = w_press & w_level;
  assign w_single     = $onehot(w_press_evt);
  assign w_multi      = (w_press_evt != '0) && !w_single;
  assign w_timer_done = (r_timer == TIMER_W'(TIMEOUT_CYC - 1));
  assign w_ack_done   = (r_ack_cnt == ACKC_W'(ACK_CYC - 1));

  // Ballot sequencer: result mode overrides everything, then per-state rules
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_mode         <= 1'b0;
      r_vote_pulse   <= '0;
      r_ballot_ready <= 1'b0;
      r_vote_ack     <= 1'b0;
      r_multi_err    <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_total_votes  <= '0;
      r_timer        <= '0;
      r_ack_cnt      <= '0;
    end else begin
      r_mode        <= bus.mode;
      r_vote_pulse  <= '0;
      r_multi_err   <= 1'b0;
      r_timeout_err <= 1'b0;

      if (bus.mode) begin
        r_state        <= RESULT;
        r_ballot_ready <= 1'b0;
        r_vote_ack     <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.ballot_issue) begin
              r_state        <= ARMED;
              r_ballot_ready <= 1'b1;
              r_timer        <= '0;
            end
          end

          ARMED: begin
            if (w_single) begin
              r_state        <= ACK;
              r_vote_pulse   <= w_press_evt;
              r_total_votes  <= sat_inc(r_total_votes);
              r_ballot_ready <= 1'b0;
              r_vote_ack     <= 1'b1;
              r_ack_cnt      <= '0;
            end else begin
              if (w_multi) begin
                r_multi_err <= 1'b1;
              end
              if (w_timer_done) begin
                r_state        <= IDLE;
                r_timeout_err  <= 1'b1;
                r_ballot_ready <= 1'b0;
              end else begin
                r_timer <= r_timer + TIMER_W'(1);
              end
            end
          end

          ACK: begin
            if (w_ack_done) begin
              r_state    <= IDLE;
              r_vote_ack <= 1'b0;
            end else begin
              r_ack_cnt <= r_ack_cnt + ACKC_W'(1);
            end
          end

          RESULT: begin
            r_state <= IDLE;
          end

          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.vote_pulse      = r_vote_pulse;
  assign bus.count_mode      = r_mode;
  assign bus.ballot_ready    = r_ballot_ready;
  assign bus.vote_ack        = r_vote_ack;
  assign bus.multi_press_err = r_multi_err;
  assign bus.timeout_err     = r_timeout_err;
  assign bus.total_votes     = r_total_votes;

endmodule

// File: tb/tb_evm_ballot_controller.sv
// tb_evm_ballot_controller: drives directed scenarios and a randomized
// phase into evm_ballot_controller. A behavioural model tracks a sample
// history per button and the ballot/ack/result situation, and a compare
// process checks every output against it on each falling clock edge.
module tb_evm_ballot_controller;

  localparam int NC   = 6;
  localparam int DEB  = 4;
  localparam int ACKC = 8;
  localparam int TOUT = 1000;

  logic clock = 1'b0;
  logic reset = 1'b0;

  int checks = 0;
  int errors = 0;
  bit compareOn = 1'b0;

  evm_ballot_controller_if #(.NUM_CAND(NC)) bus ();

  evm_ballot_controller #(
    .NUM_CAND     (NC),
    .DEBOUNCE_CYC (DEB),
    .ACK_CYC      (ACKC),
    .TIMEOUT_CYC  (TOUT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Behavioural model state
  logic [NC-1:0] rawHist [0:DEB+1];
  logic [NC-1:0] mLevel = '0;
  logic [NC-1:0] mPressPend = '0;
  logic [NC-1:0] mRise;
  bit            mOpen = 1'b0;
  bit            mResult = 1'b0;
  bit            mAllOpp;
  int            mAge = 0;
  int            mAckLeft = 0;
  int            mN;
  logic [15:0]   mTotal = '0;
  logic [NC-1:0] expPulse = '0;
  bit            expMulti = 1'b0;
  bit            expTout = 1'b0;
  bit            expCountMode = 1'b0;

  logic [NC-1:0] btn;
  int            sel;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      if (errors <= 40) begin
        $display("[TB] FAIL %s got=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
    end
  endtask

  task automatic applyStimulus(input logic [NC-1:0] buttons, input int cycles);
    bus.button = buttons;
    repeat (cycles) @(negedge clock);
  endtask

  task automatic issueBallot();
    bus.ballot_issue = 1'b1;
    @(negedge clock);
    bus.ballot_issue = 1'b0;
  endtask

  // Model: one voting opportunity per ballot, presses from the sample history
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j <= DEB + 1; j++) rawHist[j] = '0;
      mLevel = '0; mPressPend = '0; mOpen = 0; mResult = 0;
      mAge = 0; mAckLeft = 0; mTotal = '0;
      expPulse = '0; expMulti = 0; expTout = 0; expCountMode = 0;
    end else begin
      expPulse = '0; expMulti = 0; expTout = 0;
      expCountMode = bus.mode;
      mN = $countones(mPressPend);
      if (bus.mode) begin
        mResult = 1; mOpen = 0; mAckLeft = 0;
      end else if (mResult) begin
        mResult = 0;
      end else if (mAckLeft > 0) begin
        mAckLeft--;
      end else if (mOpen) begin
        if (mN == 1) begin
          expPulse = mPressPend;
          if (mTotal != 16'hFFFF) mTotal = mTotal + 16'd1;
          mOpen = 0;
          mAckLeft = ACKC;
        end else begin
          mAge++;
          if (mN >= 2) expMulti = 1;
          if (mAge == TOUT) begin
            expTout = 1;
            mOpen = 0;
          end
        end
      end else if (bus.ballot_issue) begin
        mOpen = 1;
        mAge = 0;
      end
      for (int j = DEB + 1; j > 0; j--) rawHist[j] = rawHist[j-1];
      rawHist[0] = bus.button;
      mRise = '0;
      for (int b = 0; b < NC; b++) begin
        mAllOpp = 1;
        for (int j = 2; j <= DEB + 1; j++) begin
          if (rawHist[j][b] == mLevel[b]) mAllOpp = 0;
        end
        if (mAllOpp) begin
          if (!mLevel[b]) mRise[b] = 1'b1;
          mLevel[b] = ~mLevel[b];
        end
      end
      mPressPend = mRise;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clock) begin
    if (reset && compareOn) begin
      checkOutput("cyc_vote_pulse", 32'(bus.vote_pulse), 32'(expPulse));
      checkOutput("cyc_count_mode", 32'(bus.count_mode), 32'(expCountMode));
      checkOutput("cyc_ballot_ready", 32'(bus.ballot_ready), 32'(mOpen));
      checkOutput("cyc_vote_ack", 32'(bus.vote_ack), 32'(mAckLeft > 0));
      checkOutput("cyc_multi_err", 32'(bus.multi_press_err), 32'(expMulti));
      checkOutput("cyc_timeout_err", 32'(bus.timeout_err), 32'(expTout));
      checkOutput("cyc_total_votes", 32'(bus.total_votes), 32'(mTotal));
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_pulse"}, 32'(bus.vote_pulse), 0);
    checkOutput({tag, "_count_mode"}, 32'(bus.count_mode), 0);
    checkOutput({tag, "_ready"}, 32'(bus.ballot_ready), 0);
    checkOutput({tag, "_ack"}, 32'(bus.vote_ack), 0);
    checkOutput({tag, "_multi"}, 32'(bus.multi_press_err), 0);
    checkOutput({tag, "_tout"}, 32'(bus.timeout_err), 0);
    checkOutput({tag, "_total"}, 32'(bus.total_votes), 0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.mode = 1'b0;
    bus.ballot_issue = 1'b0;
    bus.button = '0;
    btn = '0;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checkAllZero("reset");
    reset = 1'b1;
    compareOn = 1'b1;
    @(negedge clock);

    // Single vote on candidate 2 with its acknowledgement window
    $display("[TB] single vote");
    issueBallot();
    checkOutput("t1_ready", 32'(bus.ballot_ready), 1);
    applyStimulus(6'b000100, 6);
    checkOutput("t1_no_pulse_yet", 32'(bus.vote_pulse), 0);
    @(negedge clock);
    checkOutput("t1_pulse", 32'(bus.vote_pulse), 32'h04);
    checkOutput("t1_total", 32'(bus.total_votes), 1);
    checkOutput("t1_ack_on", 32'(bus.vote_ack), 1);
    repeat (3) @(negedge clock);
    applyStimulus(6'b000000, 4);
    checkOutput("t1_ack_last", 32'(bus.vote_ack), 1);
    @(negedge clock);
    checkOutput("t1_ack_off", 32'(bus.vote_ack), 0);
    checkOutput("t1_idle_ready", 32'(bus.ballot_ready), 0);
    applyStimulus(6'b000000, 10);

    // Simultaneous presses rejected, then a lone press accepted
    $display("[TB] multi press");
    issueBallot();
    applyStimulus(6'b010001, 7);
    checkOutput("t2_multi", 32'(bus.multi_press_err), 1);
    checkOutput("t2_no_pulse", 32'(bus.vote_pulse), 0);
    checkOutput("t2_ready", 32'(bus.ballot_ready), 1);
    @(negedge clock);
    checkOutput("t2_multi_off", 32'(bus.multi_press_err), 0);
    applyStimulus(6'b000000, 10);
    applyStimulus(6'b000010, 7);
    checkOutput("t2_pulse", 32'(bus.vote_pulse), 32'h02);
    checkOutput("t2_total", 32'(bus.total_votes), 2);
    applyStimulus(6'b000000, 20);

    // Ballot expiry with no press
    $display("[TB] timeout");
    issueBallot();
    repeat (TOUT - 1) @(negedge clock);
    checkOutput("t3_ready_before", 32'(bus.ballot_ready), 1);
    checkOutput("t3_tout_before", 32'(bus.timeout_err), 0);
    @(negedge clock);
    checkOutput("t3_tout", 32'(bus.timeout_err), 1);
    checkOutput("t3_ready_after", 32'(bus.ballot_ready), 0);
    applyStimulus(6'b100000, 10);
    applyStimulus(6'b000000, 10);
    checkOutput("t3_total_same", 32'(bus.total_votes), 2);

    // Bouncing button, then a held button across a second ballot
    $display("[TB] bounce and hold");
    issueBallot();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(6'b001000, 2);
      applyStimulus(6'b000000, 1);
    end
    applyStimulus(6'b001000, 6);
    checkOutput("t4_no_pulse_yet", 32'(bus.vote_pulse), 0);
    @(negedge clock);
    checkOutput("t4_pulse", 32'(bus.vote_pulse), 32'h08);
    checkOutput("t4_total", 32'(bus.total_votes), 3);
    repeat (20) @(negedge clock);
    issueBallot();
    repeat (20) @(negedge clock);
    checkOutput("t4_held_total", 32'(bus.total_votes), 3);
    checkOutput("t4_held_ready", 32'(bus.ballot_ready), 1);
    applyStimulus(6'b000000, 10);
    applyStimulus(6'b001000, 7);
    checkOutput("t4_repress_pulse", 32'(bus.vote_pulse), 32'h08);
    checkOutput("t4_repress_total", 32'(bus.total_votes), 4);
    applyStimulus(6'b000000, 20);

    // Result mode wins over a press landing on the same edge
    $display("[TB] result mode");
    issueBallot();
    applyStimulus(6'b000001, 6);
    bus.mode = 1'b1;
    @(negedge clock);
    checkOutput("t5_race_pulse", 32'(bus.vote_pulse), 0);
    checkOutput("t5_race_count_mode", 32'(bus.count_mode), 1);
    checkOutput("t5_race_ready", 32'(bus.ballot_ready), 0);
    bus.mode = 1'b0;
    applyStimulus(6'b000000, 10);
    issueBallot();
    bus.mode = 1'b1;
    @(negedge clock);
    checkOutput("t5_count_mode", 32'(bus.count_mode), 1);
    checkOutput("t5_ready", 32'(bus.ballot_ready), 0);
    applyStimulus(6'b000010, 10);
    applyStimulus(6'b000000, 10);
    bus.mode = 1'b0;
    @(negedge clock);
    checkOutput("t5_count_mode_off", 32'(bus.count_mode), 0);
    applyStimulus(6'b000010, 10);
    applyStimulus(6'b000000, 10);
    checkOutput("t5_total", 32'(bus.total_votes), 4);
    checkOutput("t5_ready_idle", 32'(bus.ballot_ready), 0);

    // Randomized traffic checked only by the model
    $display("[TB] random phase");
    for (int cyc = 0; cyc < 4000; cyc++) begin
      bus.ballot_issue = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 9) == 0) begin
        sel = int'($urandom_range(0, 9));
        if (sel < 4) btn = '0;
        else if (sel < 8) btn = NC'(1) << $urandom_range(0, NC - 1);
        else if (sel == 8) btn = (NC'(1) << $urandom_range(0, NC - 1)) | (NC'(1) << $urandom_range(0, NC - 1));
        else btn = NC'($urandom);
      end
      if (bus.mode) begin
        if ($urandom_range(0, 29) == 0) bus.mode = 1'b0;
      end else if ($urandom_range(0, 499) == 0) begin
        bus.mode = 1'b1;
      end
      bus.button = btn;
      @(negedge clock);
    end
    bus.ballot_issue = 1'b0;
    btn = '0;
    bus.mode = 1'b1;
    applyStimulus(6'b000000, 2);
    bus.mode = 1'b0;
    applyStimulus(6'b000000, 30);

    // Saturation of the vote counter
    $display("[TB] saturation");
    @(posedge clock);
    #1;
    force dut.r_total_votes = 16'hFFFE;
    mTotal = 16'hFFFE;
    @(posedge clock);
    #1;
    release dut.r_total_votes;
    @(negedge clock);
    issueBallot();
    applyStimulus(6'b010000, 7);
    checkOutput("t6_pulse_a", 32'(bus.vote_pulse), 32'h10);
    checkOutput("t6_total_a", 32'(bus.total_votes), 32'hFFFF);
    applyStimulus(6'b000000, 20);
    issueBallot();
    applyStimulus(6'b000100, 7);
    checkOutput("t6_pulse_b", 32'(bus.vote_pulse), 32'h04);
    checkOutput("t6_total_b", 32'(bus.total_votes), 32'hFFFF);

    // Reset in the middle of the acknowledgement window
    $display("[TB] reset mid-ack");
    repeat (2) @(negedge clock);
    checkOutput("t7_ack_before", 32'(bus.vote_ack), 1);
    #2;
    reset = 1'b0;
    #1;
    checkAllZero("t7_async");
    @(negedge clock);
    reset = 1'b1;
    repeat (15) @(negedge clock);
    checkOutput("t7_total_after", 32'(bus.total_votes), 0);
    checkOutput("t7_ready_after", 32'(bus.ballot_ready), 0);
    applyStimulus(6'b000000, 10);

    compareOn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
